// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU fetch, LSU memory) to one-slave AXI4-Lite arbiter.
// One whole single-beat transaction is granted at a time (AR+R or AW+W+B). Channels are routed
// combinationally while a master holds the grant. The LSU sees AW and W accepted together in a
// single cycle, even when the slave accepts the two channels in different cycles.
// Ports:
//   clock, rstn         system clock, synchronous active-low reset
//   ifu_ar*/ifu_r*      IFU read address / read data channels
//   lsu_ar*/lsu_r*      LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*  LSU write address / write data / write response channels
//   s_*                 master-side channels toward the single memory/peripheral slave
module ysyx_23060025_axi_arbiter #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,
  // IFU read
  input  logic [ADDR_LEN-1:0] ifu_araddr,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read
  input  logic [ADDR_LEN-1:0] lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write
  input  logic [ADDR_LEN-1:0] lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [3:0]          lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Slave side
  output logic [ADDR_LEN-1:0] s_araddr,
  output logic [2:0]          s_arsize,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_LEN-1:0] s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_LEN-1:0] s_awaddr,
  output logic [2:0]          s_awsize,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_LEN-1:0] s_wdata,
  output logic [3:0]          s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  typedef enum logic [1:0] {StIdle, StIfuRd, StLsuRd, StLsuWr} state_e;

  localparam logic GrantIfu = 1'b0;
  localparam logic GrantLsu = 1'b1;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ifu_req, lsu_req;
  logic   aw_ok, w_ok;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= GrantIfu;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    ifu_req      = ifu_arvalid;
    lsu_req      = lsu_arvalid | lsu_awvalid;
    aw_ok        = 1'b0;
    w_ok         = 1'b0;

    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    s_araddr    = '0;
    s_arsize    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awsize    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;

    // Outputs stay quiet while reset is asserted, whatever state is still held.
    if (rstn) begin
      unique case (state_q)
        StIdle: begin
          // On a tie, the master that did not win last time gets the grant.
          if (ifu_req && (!lsu_req || last_grant_q == GrantLsu)) begin
            state_d      = StIfuRd;
            last_grant_d = GrantIfu;
          end else if (lsu_req) begin
            state_d      = lsu_arvalid ? StLsuRd : StLsuWr;
            last_grant_d = GrantLsu;
          end
        end
        StIfuRd: begin
          s_araddr    = ifu_araddr;
          s_arsize    = ifu_arsize;
          s_arvalid   = ifu_arvalid;
          ifu_arready = s_arready;
          ifu_rdata   = s_rdata;
          ifu_rresp   = s_rresp;
          ifu_rvalid  = s_rvalid;
          s_rready    = ifu_rready;
          if (s_rvalid && ifu_rready) state_d = StIdle;
        end
        StLsuRd: begin
          s_araddr    = lsu_araddr;
          s_arsize    = lsu_arsize;
          s_arvalid   = lsu_arvalid;
          lsu_arready = s_arready;
          lsu_rdata   = s_rdata;
          lsu_rresp   = s_rresp;
          lsu_rvalid  = s_rvalid;
          s_rready    = lsu_rready;
          if (s_rvalid && lsu_rready) state_d = StIdle;
        end
        StLsuWr: begin
          s_awaddr  = lsu_awaddr;
          s_awsize  = lsu_awsize;
          s_awvalid = lsu_awvalid & ~aw_done_q;
          s_wdata   = lsu_wdata;
          s_wstrb   = lsu_wstrb;
          s_wvalid  = lsu_wvalid & ~w_done_q;
          // Remember each half once the slave takes it; release the LSU only when both are in.
          aw_ok       = aw_done_q | (s_awvalid & s_awready);
          w_ok        = w_done_q | (s_wvalid & s_wready);
          lsu_awready = aw_ok & w_ok;
          lsu_wready  = aw_ok & w_ok;
          if (aw_ok && w_ok) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
          end
          lsu_bresp  = s_bresp;
          lsu_bvalid = s_bvalid;
          s_bready   = lsu_bready;
          if (s_bvalid && lsu_bready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
module tb_ysyx_23060025_axi_arbiter;

  logic        clock = 1'b0;
  logic        rstn;
  logic [31:0] ifu_araddr;
  logic [2:0]  ifu_arsize;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic [2:0]  lsu_awsize;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arsize;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awsize;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;

  int n_cmp = 0;
  int n_bad = 0;

  wire [35:0]  ifu_outs = {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid};
  wire [40:0]  lsu_outs = {lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                           lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid};
  wire [110:0] s_outs   = {s_araddr, s_arsize, s_arvalid, s_rready, s_awaddr, s_awsize,
                           s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};

  always #5 clock = ~clock;

  ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock(clock), .rstn(rstn),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // Advance to just after the next rising edge; inputs change there, checks follow a #1 settle.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arsize = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awsize = '0; lsu_awvalid = 0;
    lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; s_rvalid = 1; s_bvalid = 1;
    tick(); tick();
    #1;
    n_cmp++;
    if ({ifu_outs, lsu_outs, s_outs} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got ifu=%h lsu=%h s=%h, want all 0",
                        ifu_outs, lsu_outs, s_outs);
    end
    clear_inputs();
    rstn = 1;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_arvalid = 1; ifu_rready = 1;
    #1;
    n_cmp++;
    if (s_arvalid !== 1'b0) begin
      n_bad++; $display("FAIL ifu_grant_latency: s_arvalid=%b want 0", s_arvalid);
    end
    tick();
    #1;
    n_cmp++;
    if ({s_arvalid, s_araddr, s_arsize, ifu_arready} !== {1'b1, 32'h3000_0000, 3'd2, 1'b0}) begin
      n_bad++; $display("FAIL ifu_ar_fwd: valid=%b addr=%h size=%0d rdy=%b want 1 30000000 2 0",
                        s_arvalid, s_araddr, s_arsize, ifu_arready);
    end
    tick();
    s_arready = 1;
    #1;
    n_cmp++;
    if (ifu_arready !== 1'b1) begin
      n_bad++; $display("FAIL ifu_arready: got %b want 1", ifu_arready);
    end
    tick();
    ifu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    #1;
    n_cmp++;
    if ({ifu_rvalid, ifu_rdata, ifu_rresp, s_rready} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1}) begin
      n_bad++; $display("FAIL ifu_r_fwd: rvalid=%b rdata=%h rresp=%b s_rready=%b want 1 deadbeef 00 1",
                        ifu_rvalid, ifu_rdata, ifu_rresp, s_rready);
    end
    n_cmp++;
    if (lsu_outs !== '0) begin
      n_bad++; $display("FAIL ifu_lsu_quiet: lsu outputs %h want 0", lsu_outs);
    end
    tick();
    #1;
    // Back in IDLE with the slave still showing rvalid: nothing forwarded.
    n_cmp++;
    if ({s_rready, ifu_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL ifu_exit_idle: s_rready=%b ifu_rvalid=%b want 0 0", s_rready, ifu_rvalid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    ifu_araddr = 32'h3000_0010; ifu_arvalid = 1; ifu_rready = 1;
    lsu_araddr = 32'h8000_0100; lsu_arvalid = 1; lsu_rready = 1;
    tick();
    s_arready = 1;
    #1;
    n_cmp++;
    if ({s_araddr, lsu_arready, ifu_arready} !== {32'h8000_0100, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL rr_lsu_first: addr=%h lsu_rdy=%b ifu_rdy=%b want 80000100 1 0",
                        s_araddr, lsu_arready, ifu_arready);
    end
    tick();
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h1111_2222;
    #1;
    n_cmp++;
    if ({lsu_rvalid, lsu_rdata, ifu_rvalid} !== {1'b1, 32'h1111_2222, 1'b0}) begin
      n_bad++; $display("FAIL rr_lsu_r: lsu_rvalid=%b rdata=%h ifu_rvalid=%b want 1 11112222 0",
                        lsu_rvalid, lsu_rdata, ifu_rvalid);
    end
    tick();
    s_rvalid = 0;
    #1;
    n_cmp++;
    if (s_arvalid !== 1'b0) begin
      n_bad++; $display("FAIL rr_idle_gap: s_arvalid=%b want 0", s_arvalid);
    end
    // Both still requesting; last winner was LSU so IFU wins this tie.
    tick();
    s_arready = 1;
    #1;
    n_cmp++;
    if ({s_araddr, ifu_arready, lsu_arready} !== {32'h3000_0010, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL rr_ifu_next: addr=%h ifu_rdy=%b lsu_rdy=%b want 30000010 1 0",
                        s_araddr, ifu_arready, lsu_arready);
    end
    tick();
    ifu_arvalid = 0; lsu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h3333_4444;
    #1;
    n_cmp++;
    if ({ifu_rvalid, ifu_rdata, lsu_rvalid} !== {1'b1, 32'h3333_4444, 1'b0}) begin
      n_bad++; $display("FAIL rr_ifu_r: ifu_rvalid=%b rdata=%h lsu_rvalid=%b want 1 33334444 0",
                        ifu_rvalid, ifu_rdata, lsu_rvalid);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_split_store();
    lsu_awaddr = 32'h8000_0004; lsu_awsize = 3'd2; lsu_awvalid = 1;
    lsu_wdata = 32'hCAFE_0000; lsu_wstrb = 4'b1100; lsu_wvalid = 1; lsu_bready = 1;
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid} !== 2'b00) begin
      n_bad++; $display("FAIL st_latency: s_awvalid=%b s_wvalid=%b want 0 0", s_awvalid, s_wvalid);
    end
    tick();
    s_awready = 1;
    #1;
    n_cmp++;
    if ({s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, lsu_awready, lsu_wready} !==
        {1'b1, 32'h8000_0004, 1'b1, 32'hCAFE_0000, 4'b1100, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL st_cycle_n: awv=%b awaddr=%h wv=%b wdata=%h strb=%b awr=%b wr=%b",
                        s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, lsu_awready, lsu_wready);
    end
    tick();
    s_awready = 0;
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid, lsu_awready, lsu_wready} !== 4'b0100) begin
      n_bad++; $display("FAIL st_cycle_n1: awv=%b wv=%b awr=%b wr=%b want 0 1 0 0",
                        s_awvalid, s_wvalid, lsu_awready, lsu_wready);
    end
    tick();
    s_wready = 1;
    #1;
    n_cmp++;
    if ({lsu_awready, lsu_wready} !== 2'b11) begin
      n_bad++; $display("FAIL st_cycle_n2: awr=%b wr=%b want 1 1", lsu_awready, lsu_wready);
    end
    tick();
    lsu_awvalid = 0; lsu_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b00;
    #1;
    n_cmp++;
    if ({lsu_bvalid, lsu_bresp, s_bready, lsu_awready} !== {1'b1, 2'b00, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL st_b: bvalid=%b bresp=%b s_bready=%b awr=%b want 1 00 1 0",
                        lsu_bvalid, lsu_bresp, s_bready, lsu_awready);
    end
    tick();
    #1;
    n_cmp++;
    if ({s_bready, lsu_bvalid} !== 2'b00) begin
      n_bad++; $display("FAIL st_exit: s_bready=%b lsu_bvalid=%b want 0 0", s_bready, lsu_bvalid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_error_resp();
    lsu_araddr = 32'h1000_0000; lsu_arvalid = 1; lsu_rready = 1;
    tick();
    s_arready = 1;
    tick();
    lsu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h55AA_55AA;
    #1;
    n_cmp++;
    if ({lsu_rvalid, lsu_rresp, lsu_rdata} !== {1'b1, 2'b10, 32'h55AA_55AA}) begin
      n_bad++; $display("FAIL err_rresp: rvalid=%b rresp=%b rdata=%h want 1 10 55aa55aa",
                        lsu_rvalid, lsu_rresp, lsu_rdata);
    end
    tick();
    clear_inputs();
    // Store where the slave takes AW and W in the same cycle.
    lsu_awaddr = 32'h8000_0008; lsu_awvalid = 1; lsu_wdata = 32'h0000_00FF; lsu_wstrb = 4'b0001;
    lsu_wvalid = 1; lsu_bready = 1;
    tick();
    s_awready = 1; s_wready = 1;
    #1;
    n_cmp++;
    if ({lsu_awready, lsu_wready} !== 2'b11) begin
      n_bad++; $display("FAIL err_joint_accept: awr=%b wr=%b want 1 1", lsu_awready, lsu_wready);
    end
    tick();
    lsu_awvalid = 0; lsu_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b11;
    #1;
    n_cmp++;
    if ({lsu_bvalid, lsu_bresp} !== {1'b1, 2'b11}) begin
      n_bad++; $display("FAIL err_bresp: bvalid=%b bresp=%b want 1 11", lsu_bvalid, lsu_bresp);
    end
    tick();
    clear_inputs();
    ifu_araddr = 32'h3000_0020; ifu_arvalid = 1;
    tick();
    #1;
    n_cmp++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h3000_0020}) begin
      n_bad++; $display("FAIL err_exit_regrant: s_arvalid=%b addr=%h want 1 30000020",
                        s_arvalid, s_araddr);
    end
    s_arready = 1;
    tick();
    ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; ifu_rready = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    lsu_awaddr = 32'h8000_0010; lsu_awvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
    lsu_wvalid = 1; lsu_bready = 1;
    tick();
    s_awready = 1;
    tick();
    s_awready = 0;
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid} !== 2'b01) begin
      n_bad++; $display("FAIL rst_aw_done: awv=%b wv=%b want 0 1", s_awvalid, s_wvalid);
    end
    rstn = 0;
    #1;
    n_cmp++;
    if ({ifu_outs, lsu_outs, s_outs} !== '0) begin
      n_bad++; $display("FAIL rst_during: ifu=%h lsu=%h s=%h want all 0", ifu_outs, lsu_outs, s_outs);
    end
    tick();
    rstn = 1;
    // Tie right after reset: last_grant restored to IFU, so the LSU store wins.
    ifu_araddr = 32'h3000_0040; ifu_arvalid = 1; ifu_rready = 1;
    #1;
    n_cmp++;
    if ({ifu_outs, lsu_outs, s_outs} !== '0) begin
      n_bad++; $display("FAIL rst_idle: ifu=%h lsu=%h s=%h want all 0", ifu_outs, lsu_outs, s_outs);
    end
    tick();
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid, s_arvalid} !== 3'b110) begin
      n_bad++; $display("FAIL rst_flags_cleared: awv=%b wv=%b arv=%b want 1 1 0",
                        s_awvalid, s_wvalid, s_arvalid);
    end
    s_awready = 1; s_wready = 1;
    tick();
    lsu_awvalid = 0; lsu_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
    tick();
    s_bvalid = 0;
    tick();
    #1;
    n_cmp++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h3000_0040}) begin
      n_bad++; $display("FAIL rst_new_ifu: s_arvalid=%b addr=%h want 1 30000040", s_arvalid, s_araddr);
    end
    s_arready = 1;
    tick();
    ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'hABCD_0001;
    #1;
    n_cmp++;
    if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'hABCD_0001}) begin
      n_bad++; $display("FAIL rst_new_ifu_r: rvalid=%b rdata=%h want 1 abcd0001", ifu_rvalid, ifu_rdata);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_idle_rvalid();
    s_rvalid = 1; s_rdata = 32'hBAD0_BAD0; ifu_rready = 1; lsu_rready = 1;
    #1;
    n_cmp++;
    if ({s_rready, ifu_rvalid, lsu_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL idle_rvalid: s_rready=%b ifu_rv=%b lsu_rv=%b want 0 0 0",
                        s_rready, ifu_rvalid, lsu_rvalid);
    end
    tick(); tick();
    #1;
    n_cmp++;
    if ({s_rready, ifu_rvalid, lsu_rvalid, s_arvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_stays: s_rready=%b ifu_rv=%b lsu_rv=%b arv=%b want 0",
                        s_rready, ifu_rvalid, lsu_rvalid, s_arvalid);
    end
    clear_inputs();
    ifu_araddr = 32'h3000_0080; ifu_arvalid = 1;
    tick();
    #1;
    n_cmp++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h3000_0080}) begin
      n_bad++; $display("FAIL idle_then_grant: arv=%b addr=%h want 1 30000080", s_arvalid, s_araddr);
    end
    clear_inputs();
    rstn = 0;
    tick();
    rstn = 1;
  endtask

  initial begin
    rstn = 0;
    clear_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_split_store();
    test_error_resp();
    test_reset_mid_write();
    test_idle_rvalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
